// File: rtl/down_counter_load.sv
// Loadable down counter with registered borrow-out pulse.
// Reloads the last loaded value on underflow, or stops and returns to idle when AUTO_RELOAD=0.
module down_counter_load #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter bit               AUTO_RELOAD = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             CE,
    input  logic             ABORT,
    output logic [WIDTH-1:0] O,
    output logic             BOUT,
    output logic             ZERO,
    output logic             BUSY
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       st_q,   st_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] rld_q,  rld_d;
    logic             bout_q, bout_d;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        rld_d  = rld_q;
        bout_d = 1'b0;
        // ABORT outranks a load even in IDLE, so an abort cycle never starts a new run
        if (ABORT) begin
            st_d = ST_IDLE;
        end else if (st_q == ST_IDLE) begin
            if (LOAD_VALID) begin
                cnt_d = LOAD_DATA;
                rld_d = LOAD_DATA;
                st_d  = ST_RUN;
            end
        end else if (CE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                bout_d = 1'b1;
                if (AUTO_RELOAD) begin
                    cnt_d = rld_q;
                end else begin
                    cnt_d = '0;
                    st_d  = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            st_q   <= ST_IDLE;
            cnt_q  <= INIT;
            rld_q  <= INIT;
            bout_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rld_q  <= rld_d;
            bout_q <= bout_d;
        end
    end

    assign O          = cnt_q;
    assign BOUT       = bout_q;
    assign ZERO       = (cnt_q == '0);
    assign BUSY       = (st_q == ST_RUN);
    assign LOAD_READY = (st_q == ST_IDLE);

endmodule

// File: tb/tb_down_counter_load.sv
// Directed bench for down_counter_load: an auto-reload and a one-shot instance
// share all inputs and are checked against hand-computed values.
module tb_down_counter_load;

    logic       clk = 1'b0;
    logic       rst, lv, ce, ab;
    logic [3:0] ld;

    logic       a_rdy, a_bout, a_zero, a_busy;
    logic [3:0] a_o;
    logic       s_rdy, s_bout, s_zero, s_busy;
    logic [3:0] s_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    down_counter_load #(.WIDTH(4), .INIT(4'd5), .AUTO_RELOAD(1'b1)) u_ar (
        .CLK(clk), .RESET(rst), .LOAD_VALID(lv), .LOAD_READY(a_rdy), .LOAD_DATA(ld),
        .CE(ce), .ABORT(ab), .O(a_o), .BOUT(a_bout), .ZERO(a_zero), .BUSY(a_busy)
    );

    down_counter_load #(.WIDTH(4), .INIT(4'd5), .AUTO_RELOAD(1'b0)) u_os (
        .CLK(clk), .RESET(rst), .LOAD_VALID(lv), .LOAD_READY(s_rdy), .LOAD_DATA(ld),
        .CE(ce), .ABORT(ab), .O(s_o), .BOUT(s_bout), .ZERO(s_zero), .BUSY(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lv = 1'b0; ce = 1'b0; ab = 1'b0; ld = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        lv = 1'b1; ld = v;
        tick();
        lv = 1'b0;
    endtask

    logic [3:0] seq2 [8] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};

    initial begin
        rst = 1'b1; lv = 1'b0; ce = 1'b0; ab = 1'b0; ld = 4'd0;

        // 1: reset state
        do_reset();
        chk("rst_o",    a_o,    4'd5);
        chk("rst_bout", a_bout, 1'b0);
        chk("rst_rdy",  a_rdy,  1'b1);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_zero", a_zero, 1'b0);
        chk("rst_os_o", s_o,    4'd5);

        // 2: auto-reload, load 3, CE held, period 4
        load(4'd3);
        chk("ar_load_o",    a_o,    4'd3);
        chk("ar_load_busy", a_busy, 1'b1);
        chk("ar_load_rdy",  a_rdy,  1'b0);
        ce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("ar_seq_o",    a_o,    seq2[i]);
            chk("ar_seq_bout", a_bout, (seq2[i] == 4'd3));
            chk("ar_seq_zero", a_zero, (seq2[i] == 4'd0));
            chk("ar_seq_busy", a_busy, 1'b1);
        end

        // 3: one-shot, load 2
        do_reset();
        load(4'd2);
        chk("os_load_o", s_o, 4'd2);
        ce = 1'b1;
        tick(); chk("os_o1", s_o, 4'd1);
        tick(); chk("os_o0", s_o, 4'd0); chk("os_o0_bout", s_bout, 1'b0);
        tick();
        chk("os_uf_o",    s_o,    4'd0);
        chk("os_uf_bout", s_bout, 1'b1);
        chk("os_uf_busy", s_busy, 1'b0);
        chk("os_uf_rdy",  s_rdy,  1'b1);
        tick();
        chk("os_after_o",    s_o,    4'd0);
        chk("os_after_bout", s_bout, 1'b0);
        chk("os_after_busy", s_busy, 1'b0);

        // 4: load F, CE toggling; underflow on the 16th CE edge
        do_reset();
        load(4'hF);
        for (int i = 0; i < 16; i++) begin
            ce = 1'b1;
            tick();
            chk("tog_ce_o",    a_o,    (i < 15) ? 4'(14 - i) : 4'hF);
            chk("tog_ce_bout", a_bout, (i == 15));
            ce = 1'b0;
            tick();
            chk("tog_hold_o",    a_o,    (i < 15) ? 4'(14 - i) : 4'hF);
            chk("tog_hold_bout", a_bout, 1'b0);
        end

        // 5: LOAD_VALID held in RUN is ignored; ABORT+CE holds O; load taken once in IDLE
        do_reset();
        load(4'd9);
        lv = 1'b1; ld = 4'd2; ce = 1'b1;
        tick(); chk("ab_o8", a_o, 4'd8);
        tick(); chk("ab_o7", a_o, 4'd7);
        tick(); chk("ab_o6", a_o, 4'd6);
        ab = 1'b1;
        tick();
        chk("ab_o",    a_o,    4'd6);
        chk("ab_busy", a_busy, 1'b0);
        chk("ab_bout", a_bout, 1'b0);
        chk("ab_rdy",  a_rdy,  1'b1);
        ab = 1'b0; ce = 1'b0;
        tick();
        chk("ab_reload_o",    a_o,    4'd2);
        chk("ab_reload_busy", a_busy, 1'b1);
        tick();
        chk("ab_noreload_o", a_o, 4'd2);
        lv = 1'b0;

        // 6: reset on an underflow edge with LOAD_VALID high
        do_reset();
        load(4'd1);
        ce = 1'b1;
        tick();
        chk("rs_pre_a", a_o, 4'd0);
        chk("rs_pre_s", s_o, 4'd0);
        rst = 1'b1; lv = 1'b1; ld = 4'd7;
        tick();
        chk("rs_a_o",    a_o,    4'd5);
        chk("rs_a_bout", a_bout, 1'b0);
        chk("rs_a_busy", a_busy, 1'b0);
        chk("rs_s_o",    s_o,    4'd5);
        chk("rs_s_bout", s_bout, 1'b0);
        chk("rs_s_rdy",  s_rdy,  1'b1);
        rst = 1'b0; lv = 1'b0; ce = 1'b0;
        tick();
        chk("rs_after_o", a_o, 4'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
